// File: rtl/fsm_input_conditioner_if.sv
// Signal bundle between the raw board inputs and the sequence FSM front end.
// The master side drives the raw pins; the slave side is the conditioner.
interface fsm_input_conditioner_if #(
   parameter int SW_WIDTH = 4
) ();
   logic                key_n;
   logic [SW_WIDTH-1:0] sw_in;
   logic                tick_1hz;
   logic                load_pulse;
   logic                key_level;
   logic [SW_WIDTH-1:0] sw_sync;

   modport master (
      output key_n, sw_in,
      input  tick_1hz, load_pulse, key_level, sw_sync
   );

   modport slave (
      input  key_n, sw_in,
      output tick_1hz, load_pulse, key_level, sw_sync
   );
endinterface

// File: rtl/fsm_input_conditioner.sv
// Input front end for the sequence FSM. It produces a 1 Hz step enable, a
// debounced KEY0 load strobe and synchronised switches, all in the clk domain.
module fsm_input_conditioner #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int SW_WIDTH        = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   fsm_input_conditioner_if.slave bus
);
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

   logic                key_meta;
   logic                key_s;
   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_q;
   deb_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic                load_q;
   logic                level_q;
   logic [PRE_W-1:0]    presc;
   logic                tick_q;
   logic                load_fire;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value,
   // which is what makes the two-stage synchroniser a real two-stage chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_meta <= 1'b1;
         key_s    <= 1'b1;
         sw_meta  <= '0;
         sw_q     <= '0;
      end else begin
         key_meta <= bus.key_n;
         key_s    <= key_meta;
         sw_meta  <= bus.sw_in;
         sw_q     <= sw_meta;
      end
   end

   // The edge on which the debouncer accepts a press; shared with the prescaler.
   assign load_fire = (state == PRESS_WAIT) && !key_s && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         load_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         load_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!key_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (key_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (load_fire) begin
                  state   <= PRESSED;
                  load_q  <= 1'b1;
                  level_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (key_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (!key_s) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE;
                  level_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A load restarts the step period so the FSM never sees load and step together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         tick_q <= 1'b0;
      end else if (load_fire) begin
         presc  <= '0;
         tick_q <= 1'b0;
      end else if (presc == PRE_LAST) begin
         presc  <= '0;
         tick_q <= 1'b1;
      end else begin
         presc  <= presc + 1'b1;
         tick_q <= 1'b0;
      end
   end

   assign bus.tick_1hz   = tick_q;
   assign bus.load_pulse = load_q;
   assign bus.key_level  = level_q;
   assign bus.sw_sync    = sw_q;
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Self-checking bench for fsm_input_conditioner: a run-length behavioural model
// checked every cycle, plus directed scenarios with hand-computed edge numbers.
module tb_fsm_input_conditioner;
   localparam int TICK_DIV = 5;
   localparam int DEB      = 4;
   localparam int SW_W     = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fsm_input_conditioner_if #(.SW_WIDTH(SW_W)) bus ();

   fsm_input_conditioner #(
      .TICK_DIV(TICK_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .SW_WIDTH(SW_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: the key is seen two edges late; the accepted level flips once the
   // seen key has disagreed with it for DEB+1 consecutive edges. Ticks fall on
   // every TICK_DIV-th edge counted from reset or from the latest load.
   typedef struct {
      logic            k1, k2, level, tick, load;
      int              run, since;
      logic [SW_W-1:0] sw1, sw2;
   } model_t;

   function automatic model_t model_reset();
      model_t r;
      r.k1 = 1'b1; r.k2 = 1'b1; r.level = 1'b0; r.tick = 1'b0; r.load = 1'b0;
      r.run = 0; r.since = 0; r.sw1 = '0; r.sw2 = '0;
      return r;
   endfunction

   function automatic model_t model_step(input model_t m, input logic kn, input logic [SW_W-1:0] sw);
      model_t n = m;
      logic pressed_seen = !m.k2;
      n.k2 = m.k1;
      n.k1 = kn;
      n.sw2 = m.sw1;
      n.sw1 = sw;
      n.load = 1'b0;
      n.run = (pressed_seen != m.level) ? m.run + 1 : 0;
      if (n.run == DEB + 1) begin
         n.level = !m.level;
         n.run   = 0;
         n.load  = n.level;
      end
      if (n.load) begin
         n.since = 0;
         n.tick  = 1'b0;
      end else begin
         n.since = m.since + 1;
         n.tick  = (n.since % TICK_DIV) == 0;
      end
      return n;
   endfunction

   model_t m;
   int     edge_no;
   logic   lvl_prev = 1'b0;
   int     load_q[$];
   int     tick_q[$];
   int     up_q[$];
   int     dn_q[$];
   int     exp_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m       <= model_reset();
         edge_no <= 0;
      end else begin
         m       <= model_step(m, bus.key_n, bus.sw_in);
         edge_no <= edge_no + 1;
      end
   end

   always @(negedge clk) begin
      check("tick_1hz",   32'(bus.tick_1hz),   32'(m.tick));
      check("load_pulse", 32'(bus.load_pulse), 32'(m.load));
      check("key_level",  32'(bus.key_level),  32'(m.level));
      check("sw_sync",    32'(bus.sw_sync),    32'(m.sw2));
      if (!reset) begin
         if (bus.load_pulse) load_q.push_back(edge_no);
         if (bus.tick_1hz) tick_q.push_back(edge_no);
         if (bus.key_level && !lvl_prev) up_q.push_back(edge_no);
         if (!bus.key_level && lvl_prev) dn_q.push_back(edge_no);
      end
      lvl_prev <= bus.key_level;
   end

   task automatic check_edges(input string name, input int got[$], input int exp[$]);
      check({name, "_count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench #1 after edge 0; the next rising edge is edge 1.
   task automatic do_reset(input logic kn, input logic [SW_W-1:0] sw);
      reset = 1'b1;
      bus.key_n = kn;
      bus.sw_in = sw;
      step(2);
      reset = 1'b0;
      load_q.delete(); tick_q.delete(); up_q.delete(); dn_q.delete();
   endtask

   initial begin
      bus.key_n = 1'b0;
      bus.sw_in = 4'hA;
      step(2);
      check("t1_rst_tick",  32'(bus.tick_1hz),   0);
      check("t1_rst_load",  32'(bus.load_pulse), 0);
      check("t1_rst_level", 32'(bus.key_level),  0);
      check("t1_rst_sw",    32'(bus.sw_sync),    0);

      // Key held through reset, then reset again in the middle of PRESS_WAIT.
      reset = 1'b0;
      step(4);
      check("t1_sw_synced", 32'(bus.sw_sync), 32'hA);
      reset = 1'b1;
      #1;
      check("t1_mid_sw",    32'(bus.sw_sync),    0);
      check("t1_mid_load",  32'(bus.load_pulse), 0);
      check("t1_mid_level", 32'(bus.key_level),  0);
      do_reset(1'b0, 4'hA);
      step(20);
      exp_q = {7};
      check_edges("t1_load", load_q, exp_q);

      // Idle key: tick every TICK_DIV edges.
      do_reset(1'b1, 4'h0);
      step(16);
      exp_q = {5, 10, 15};
      check_edges("t2_tick", tick_q, exp_q);

      // Clean press from edge 1 for 20 edges, then release.
      do_reset(1'b1, 4'h0);
      bus.key_n = 1'b0;
      step(20);
      exp_q = {7};
      check_edges("t3_load", load_q, exp_q);
      check_edges("t3_level_up", up_q, exp_q);
      bus.key_n = 1'b1;
      step(10);
      exp_q = {27};
      check_edges("t3_level_dn", dn_q, exp_q);
      check("t3_no_release_pulse", load_q.size(), 1);

      // Bounce: low 3, high 2, low 3, then released.
      do_reset(1'b1, 4'h0);
      bus.key_n = 1'b0; step(3);
      bus.key_n = 1'b1; step(2);
      bus.key_n = 1'b0; step(3);
      bus.key_n = 1'b1; step(15);
      exp_q = {};
      check_edges("t4_load", load_q, exp_q);
      check_edges("t4_level_up", up_q, exp_q);

      // Press accepted on the prescaler terminal edge (edge 10).
      do_reset(1'b1, 4'h0);
      step(3);
      bus.key_n = 1'b0;
      step(13);
      exp_q = {10};
      check_edges("t5_load", load_q, exp_q);
      exp_q = {5, 15};
      check_edges("t5_tick", tick_q, exp_q);
      bus.key_n = 1'b1;
      step(10);

      // Switch change lands on sw_sync at the second edge after it.
      do_reset(1'b1, 4'h0);
      step(2);
      bus.sw_in = 4'b1011;
      step(1);
      check("t6_sw_edge1", 32'(bus.sw_sync), 0);
      step(1);
      check("t6_sw_edge2", 32'(bus.sw_sync), 32'b1011);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
